// File: rtl/bist_pkg.sv
// Shared definitions for the MISR output-response analyser used by the
// 4-bit full-adder BIST: FSM state encoding and default MISR polynomial/seed.
package bist_pkg;

  // State codes kept as plain constants so older blocks can compare against
  // raw two-bit values; the enum below reuses the same encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } bist_state_e;

  // Defaults for the full-adder CUT: 4-bit signature, 2 response bits
  // (Sum, Cout), feedback into stages 0 and 1, all-zero seed.
  localparam int         BIST_WIDTH    = 4;
  localparam int         BIST_IN_WIDTH = 2;
  localparam logic [3:0] BIST_POLY     = 4'b0011;
  localparam logic [3:0] BIST_SEED     = 4'b0000;

endpackage

// File: rtl/misr_step.sv
// Combinational next-state function of the MISR: one shift with tap feedback
// from the top stage, XORed with the (zero-extended) response word.
module misr_step
  import bist_pkg::*;
#(
  parameter int               WIDTH    = BIST_WIDTH,
  parameter int               IN_WIDTH = BIST_IN_WIDTH,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(BIST_POLY)
) (
  input  logic [WIDTH-1:0]    sig_in,
  input  logic [IN_WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]    sig_out
);

  // Response bits above IN_WIDTH contribute nothing.
  logic [WIDTH-1:0] data_ext;
  assign data_ext = WIDTH'(data_in);

  // Stage 0 always receives the feedback bit directly.
  assign sig_out[0] = sig_in[WIDTH-1] ^ data_ext[0];

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_stage
      assign sig_out[gi] = sig_in[gi-1] ^ (POLY[gi] & sig_in[WIDTH-1]) ^ data_ext[gi];
    end
  endgenerate

endmodule

// File: rtl/bist_misr_ora.sv
// MISR-based output-response analyser. A start pulse seeds the signature and
// opens a window of num_patterns qualified samples; the final signature is
// held in DONE until the next start or reset.
// Optional build macro MISR_COMPARE_EN adds the golden input and the
// registered pass/fail result, valid together with done.
module bist_misr_ora
  import bist_pkg::*;
#(
  parameter int               WIDTH    = BIST_WIDTH,
  parameter int               IN_WIDTH = BIST_IN_WIDTH,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(BIST_POLY),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(BIST_SEED),
  parameter int               CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_patterns,
  input  logic                data_valid,
  input  logic [IN_WIDTH-1:0] datain,
`ifdef MISR_COMPARE_EN
  input  logic [WIDTH-1:0]    golden,
  output logic                pass,
  output logic                fail,
`endif
  output logic [WIDTH-1:0]    signature,
  output logic                busy,
  output logic                done
);

  bist_state_e      state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] step_sig;

  misr_step #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .POLY     (POLY)
  ) u_step (
    .sig_in  (sig_q),
    .data_in (datain),
    .sig_out (step_sig)
  );

  assign cnt_next = cnt_q + CNT_W'(1);

  // Next-state: start always wins; otherwise only CAPTURE reacts to data_valid.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    if (start) begin
      sig_d = SEED;
      cnt_d = '0;
      lim_d = num_patterns;
      // An empty window has nothing to compact, so finish immediately.
      state_d = (num_patterns == '0) ? DONE : CAPTURE;
    end else if (state_q == CAPTURE && data_valid) begin
      sig_d = step_sig;
      cnt_d = cnt_next;
      if (cnt_next == lim_q) begin
        state_d = DONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign signature = sig_q;
  assign busy      = (state_q == CAPTURE);
  assign done      = (state_q == DONE);

`ifdef MISR_COMPARE_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;
  logic enter_done;

  // A restart with an empty window re-enters DONE even from DONE.
  assign enter_done = (state_d == DONE) && ((state_q != DONE) || start);

  // Verdict is captured on the same edge that raises done.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (start) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end
    if (enter_done) begin
      pass_d = (sig_d == golden);
      fail_d = (sig_d != golden);
    end
  end

  // Verdict registers, cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_bist_misr_ora.sv
// Directed bench for bist_misr_ora (WIDTH=4, IN_WIDTH=2, POLY=4'b0011).
// A second instance with SEED=4'b1000 exercises top-stage feedback.
// Honours MISR_COMPARE_EN to check golden/pass/fail.
module tb_bist_misr_ora;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_patterns = 8'd0;
  logic       data_valid = 1'b0;
  logic [1:0] datain = 2'b00;
  logic [3:0] golden = 4'h0;

  logic [3:0] signature, signature2;
  logic       busy, busy2, done, done2;
  logic       pass, fail, pass2, fail2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  bist_misr_ora #(.WIDTH(4), .IN_WIDTH(2), .POLY(4'b0011), .SEED(4'b0000), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_patterns (num_patterns),
    .data_valid   (data_valid),
    .datain       (datain),
`ifdef MISR_COMPARE_EN
    .golden       (golden),
    .pass         (pass),
    .fail         (fail),
`endif
    .signature    (signature),
    .busy         (busy),
    .done         (done)
  );

  bist_misr_ora #(.WIDTH(4), .IN_WIDTH(2), .POLY(4'b0011), .SEED(4'b1000), .CNT_W(8)) dut_s (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_patterns (num_patterns),
    .data_valid   (data_valid),
    .datain       (datain),
`ifdef MISR_COMPARE_EN
    .golden       (golden),
    .pass         (pass2),
    .fail         (fail2),
`endif
    .signature    (signature2),
    .busy         (busy2),
    .done         (done2)
  );

`ifndef MISR_COMPARE_EN
  assign pass  = 1'b0;
  assign fail  = 1'b0;
  assign pass2 = 1'b0;
  assign fail2 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (SEED = 0 instance) ----------------
  // Signature update viewed as multiply-by-x modulo the polynomial, plus input.
  function automatic logic [3:0] mul_x_add(input logic [3:0] s, input logic [1:0] d);
    logic [3:0] r;
    r = {s[2:0], 1'b0};
    if (s[3]) r = r ^ 4'b0011;
    return r ^ {2'b00, d};
  endfunction

  logic [3:0] m_sig = 4'h0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0;
  int         m_left = 0;
  logic [3:0] m_nxt;
  assign m_nxt = mul_x_add(m_sig, datain);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_sig <= 4'h0; m_busy <= 1'b0; m_done <= 1'b0;
      m_pass <= 1'b0; m_fail <= 1'b0; m_left <= 0;
    end else if (start) begin
      m_sig <= 4'h0;
      if (num_patterns == 8'd0) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_pass <= (golden == 4'h0); m_fail <= (golden != 4'h0);
      end else begin
        m_busy <= 1'b1; m_done <= 1'b0; m_left <= int'(num_patterns);
        m_pass <= 1'b0; m_fail <= 1'b0;
      end
    end else if (m_busy && data_valid) begin
      m_sig  <= m_nxt;
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_pass <= (m_nxt == golden); m_fail <= (m_nxt != golden);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_signature", 32'(signature), 32'(m_sig));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
`ifdef MISR_COMPARE_EN
      chk("model_pass", 32'(pass), 32'(m_pass));
      chk("model_fail", 32'(fail), 32'(m_fail));
`endif
    end
  end

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic st, input logic [7:0] n, input logic dv, input logic [1:0] d);
    start = st; num_patterns = n; data_valid = dv; datain = d;
    @(posedge clock);
    #1;
    start = 1'b0; data_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_signature", 32'(signature), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset  = 1'b1;
    chk_en = 1'b1;
    cyc(0, 0, 1, 2'b11);
    chk("idle_ignores_valid", 32'(signature), 32'h0);

    // Three samples of 01: 1, 3, 7; done on the third step edge.
    golden = 4'h7;
    cyc(1, 3, 1, 2'b11);       // start-cycle data is not compacted
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_seed", 32'(signature), 32'h0);
    cyc(0, 0, 1, 2'b01); chk("step1", 32'(signature), 32'h1);
    cyc(0, 0, 1, 2'b01); chk("step2", 32'(signature), 32'h3);
`ifdef MISR_COMPARE_EN
    chk("pass_not_early", 32'(pass), 32'h0);
`endif
    cyc(0, 0, 1, 2'b01); chk("step3", 32'(signature), 32'h7);
    chk("step3_done", 32'(done), 32'h1);
    chk("step3_busy", 32'(busy), 32'h0);
`ifdef MISR_COMPARE_EN
    chk("golden7_pass", 32'(pass), 32'h1);
    chk("golden7_fail", 32'(fail), 32'h0);
`endif
    cyc(0, 0, 1, 2'b11); chk("done_hold", 32'(signature), 32'h7);

    // Same window with a wrong golden.
    golden = 4'h6;
    cyc(1, 3, 0, 2'b00);
    repeat (3) cyc(0, 0, 1, 2'b01);
    chk("golden6_done", 32'(done), 32'h1);
`ifdef MISR_COMPARE_EN
    chk("golden6_pass", 32'(pass), 32'h0);
    chk("golden6_fail", 32'(fail), 32'h1);
`endif

    // Seed 1000, one zero sample: feedback lands in stages 0 and 1.
    cyc(1, 1, 0, 2'b00);
    chk("seed_load", 32'(signature2), 32'h8);
    cyc(0, 0, 1, 2'b00);
    chk("seed_feedback", 32'(signature2), 32'h3);
    chk("seed_done", 32'(done2), 32'h1);

    // Stall of two cycles mid-window.
    cyc(1, 3, 0, 2'b00);
    cyc(0, 0, 1, 2'b01);
    cyc(0, 0, 0, 2'b11); chk("stall1", 32'(signature), 32'h1);
    cyc(0, 0, 0, 2'b10); chk("stall2", 32'(signature), 32'h1);
    chk("stall_busy", 32'(busy), 32'h1);
    cyc(0, 0, 1, 2'b01);
    chk("stall_not_done", 32'(done), 32'h0);
    cyc(0, 0, 1, 2'b01); chk("stall_final", 32'(signature), 32'h7);
    chk("stall_done", 32'(done), 32'h1);

    // Empty window: DONE next cycle with the seed, busy never high.
    cyc(1, 0, 0, 2'b00);
    chk("empty_done", 32'(done), 32'h1);
    chk("empty_busy", 32'(busy), 32'h0);
    chk("empty_seed2", 32'(signature2), 32'h8);
    cyc(0, 0, 1, 2'b11); chk("empty_busy_later", 32'(busy), 32'h0);
    chk("empty_hold2", 32'(signature2), 32'h8);

    // Mixed response pattern with a stall: 3,4,9,2,4,A.
    cyc(1, 6, 0, 2'b00);
    cyc(0, 0, 1, 2'b11);
    cyc(0, 0, 1, 2'b10);
    cyc(0, 0, 0, 2'b11);
    cyc(0, 0, 1, 2'b01); chk("mixed3", 32'(signature), 32'h9);
    cyc(0, 0, 1, 2'b11); chk("mixed4", 32'(signature), 32'h2);
    cyc(0, 0, 1, 2'b00);
    cyc(0, 0, 1, 2'b10); chk("mixed_final", 32'(signature), 32'hA);
    chk("mixed_done", 32'(done), 32'h1);

    // Restart after two samples, start wins over data_valid.
    cyc(1, 3, 0, 2'b00);
    cyc(0, 0, 1, 2'b11);
    cyc(0, 0, 1, 2'b11);
    cyc(1, 3, 1, 2'b11); chk("restart_seed", 32'(signature), 32'h0);
    repeat (3) cyc(0, 0, 1, 2'b01);
    chk("restart_final", 32'(signature), 32'h7);
    chk("restart_done", 32'(done), 32'h1);

    // Reset mid-window clears outputs immediately.
    cyc(1, 5, 0, 2'b00);
    cyc(0, 0, 1, 2'b11);
    cyc(0, 0, 1, 2'b11);
    reset = 1'b0;
    #1;
    chk("async_rst_sig", 32'(signature), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) cyc(0, 0, 1, 2'b11);
    chk("post_rst_idle", 32'(busy), 32'h0);
    chk("post_rst_sig", 32'(signature), 32'h0);

    @(negedge clock);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
